// File: rtl/spc_pcx_req_issue_pkg.sv
// Shared constants for the core-side PCX request issue stage.
// Covers the packet width, the destination bit map, the per-destination outstanding limit and the issue FSM encoding.
// Contains no ports and no logic, only types, constants and one helper function.
package spc_pcx_req_issue_pkg;

    // PCX packet payload width
    localparam int PCX_WIDTH    = 124;

    // One-hot destination map: L2 banks 0..3 then the IO/FPU port
    localparam int PCX_NUM_DEST = 5;
    localparam int DEST_L2B0    = 0;
    localparam int DEST_L2B1    = 1;
    localparam int DEST_L2B2    = 2;
    localparam int DEST_L2B3    = 3;
    localparam int DEST_IO      = 4;

    // The PCX queues at most two ungranted packets per destination
    localparam int PCX_MAX_OUT  = 2;

    // Issue FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ATOM2 = 1'b1;

    typedef logic [PCX_NUM_DEST-1:0] dest_t;
    typedef logic [1:0]              out_cnt_t;

    // Grant return. The result saturates at zero, so a grant for a packet
    // that was issued before a reset is absorbed instead of wrapping.
    function automatic out_cnt_t cnt_sat_dec(input out_cnt_t cnt, input logic dec);
        return (dec && (cnt != 2'd0)) ? (cnt - 2'd1) : cnt;
    endfunction

endpackage

// File: rtl/spc_pcx_req_fifo.sv
// Request FIFO: this block holds the packets queued by the LSU in front of the issue FSM.
// Latency: a pushed entry becomes visible at the head one cycle later. The head is shown combinationally from storage.
// Backpressure: o_full is taken from the registered count only, so a pop in the same cycle does not free a slot.
// Ports: i_push/i_push_dat write the tail, i_pop drops the head, o_head_dat is the head entry,
//        o_count is the number of stored entries, o_full is set when count equals DEPTH, o_empty is set when count is zero.
module spc_pcx_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 130
) (
    input  logic                     rclk,
    input  logic                     arst_l,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_dat,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_do_push;
    logic          w_do_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    // Qualify locally so a stray push or pop can never corrupt the pointers
    assign w_do_push  = i_push & ~o_full;
    assign w_do_pop   = i_pop  & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spc_pcx_req_issue.sv
// Core-side PCX request issue stage: queues LSU packets, tracks ungranted packets per destination and issues requests.
// Latency: the request goes out 1 cycle after the entry reaches the FIFO head (PQ). The data follows 1 cycle later (PA).
// Backpressure: enq_rdy drops when the FIFO is full. A destination that already has MAX_OUT ungranted packets stalls the head.
// Ports: rclk/arst_l clock and async active-low reset. enq_* is the LSU enqueue interface.
//        spc_pcx_req_pq_buf/spc_pcx_atom_pq_buf/spc_pcx_data_pa_buf drive the PCX output buffer.
//        pcx_spc_grant_px_buf carries the per-destination grants. fifo_empty and proto_err are status outputs.
// Optional: define SPC_PCX_REQ_CHK_EN to build the sticky protocol checker. Without it proto_err is tied 0.
module spc_pcx_req_issue
    import spc_pcx_req_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PW      = PCX_WIDTH,
    parameter int MAX_OUT = PCX_MAX_OUT
) (
    input  logic                    rclk,
    input  logic                    arst_l,
    input  logic                    enq_vld,
    input  logic [PW-1:0]           enq_data,
    input  logic [PCX_NUM_DEST-1:0] enq_dest,
    input  logic                    enq_atom,
    output logic                    enq_rdy,
    output logic [PCX_NUM_DEST-1:0] spc_pcx_req_pq_buf,
    output logic                    spc_pcx_atom_pq_buf,
    output logic [PW-1:0]           spc_pcx_data_pa_buf,
    input  logic [PCX_NUM_DEST-1:0] pcx_spc_grant_px_buf,
    output logic                    fifo_empty,
    output logic                    proto_err
);

    localparam int       CW    = $clog2(DEPTH) + 1;
    localparam int       EW    = PW + PCX_NUM_DEST + 1;
    localparam out_cnt_t MAX_C = out_cnt_t'(MAX_OUT);

    // FIFO interface
    logic [EW-1:0]    w_head_ent;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_head_atom;
    dest_t            w_head_dest;
    logic [PW-1:0]    w_head_dat;

    // Issue state
    logic [0:0]       r_state;
    dest_t            r_atom_dest;
    out_cnt_t [PCX_NUM_DEST-1:0] r_out_cnt;
    logic             r_pend_vld;
    logic [PW-1:0]    r_pend_dat;

    // Issue decision
    out_cnt_t [PCX_NUM_DEST-1:0] w_cnt_ag;
    out_cnt_t [PCX_NUM_DEST-1:0] w_cnt_nxt;
    logic             w_norm_ok;
    logic             w_atom_ok;
    logic             w_issue_norm;
    logic             w_issue_atom1;
    logic             w_issue_atom2;
    logic             w_issue;
    dest_t            w_issue_dest;
    logic [0:0]       w_state_nxt;

    assign w_push     = enq_vld & ~w_full;
    assign enq_rdy    = ~w_full;
    assign fifo_empty = w_empty;

    spc_pcx_req_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .rclk       (rclk),
        .arst_l     (arst_l),
        .i_push     (w_push),
        .i_push_dat ({enq_atom, enq_dest, enq_data}),
        .i_pop      (w_issue),
        .o_head_dat (w_head_ent),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign {w_head_atom, w_head_dest, w_head_dat} = w_head_ent;

    // This cycle's grants are subtracted before the eligibility test, so a
    // slot freed by a grant can be reused in the same cycle.
    always_comb begin
        w_norm_ok = 1'b1;
        w_atom_ok = 1'b1;
        for (int d = 0; d < PCX_NUM_DEST; d++) begin
            w_cnt_ag[d] = cnt_sat_dec(r_out_cnt[d], pcx_spc_grant_px_buf[d]);
            if (w_head_dest[d]) begin
                if (w_cnt_ag[d] >= MAX_C) w_norm_ok = 1'b0;
                if (w_cnt_ag[d] != 2'd0)  w_atom_ok = 1'b0;
            end
        end
    end

    // An atomic needs both halves queued and both destination slots free.
    // Once the first half has issued, the second half goes out unconditionally
    // on the next cycle, so no other request can issue between the two halves.
    assign w_issue_norm  = (r_state == ST_IDLE) & ~w_empty & ~w_head_atom & w_norm_ok;
    assign w_issue_atom1 = (r_state == ST_IDLE) & ~w_empty &  w_head_atom & w_atom_ok
                         & (w_count >= CW'(2));
    assign w_issue_atom2 = (r_state == ST_ATOM2) & ~w_empty;
    assign w_issue       = w_issue_norm | w_issue_atom1 | w_issue_atom2;
    assign w_issue_dest  = w_issue_atom2 ? r_atom_dest : w_head_dest;

    always_comb begin
        for (int d = 0; d < PCX_NUM_DEST; d++) begin
            w_cnt_nxt[d] = w_cnt_ag[d] + {1'b0, (w_issue & w_issue_dest[d])};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_issue_atom1) begin
            w_state_nxt = ST_ATOM2;
        end else if (r_state == ST_ATOM2) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_state             <= ST_IDLE;
            r_atom_dest         <= '0;
            r_out_cnt           <= '0;
            r_pend_vld          <= 1'b0;
            r_pend_dat          <= '0;
            spc_pcx_req_pq_buf  <= '0;
            spc_pcx_atom_pq_buf <= 1'b0;
            spc_pcx_data_pa_buf <= '0;
        end else begin
            r_state             <= w_state_nxt;
            r_out_cnt           <= w_cnt_nxt;
            spc_pcx_req_pq_buf  <= w_issue ? w_issue_dest : '0;
            spc_pcx_atom_pq_buf <= w_issue_atom1;
            if (w_issue_atom1) begin
                r_atom_dest <= w_head_dest;
            end
            // The payload is staged one cycle so that it lands on PA, one cycle
            // behind its request. data_pa holds its value between issues.
            r_pend_vld <= w_issue;
            if (w_issue) begin
                r_pend_dat <= w_head_dat;
            end
            if (r_pend_vld) begin
                spc_pcx_data_pa_buf <= r_pend_dat;
            end
        end
    end

`ifdef SPC_PCX_REQ_CHK_EN
    logic w_err_grant;
    logic w_err_issue;
    logic w_err_atom;
    logic r_proto_err;

    always_comb begin
        w_err_grant = 1'b0;
        w_err_issue = 1'b0;
        for (int d = 0; d < PCX_NUM_DEST; d++) begin
            if (pcx_spc_grant_px_buf[d] && (r_out_cnt[d] == 2'd0)) w_err_grant = 1'b1;
            if (w_issue && w_issue_dest[d] && (w_cnt_ag[d] == MAX_C)) w_err_issue = 1'b1;
        end
    end

    // An atomic first half that arrives in the last free slot, with no pop in
    // the same cycle, leaves no room for its second half.
    assign w_err_atom = enq_vld & enq_atom & (w_count == CW'(DEPTH - 1)) & ~w_issue;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= r_proto_err | w_err_grant | w_err_issue | w_err_atom;
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_spc_pcx_req_issue.sv
// Directed bench for spc_pcx_req_issue.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// Each check is an immediate assertion that counts and reports any miss.
module tb_spc_pcx_req_issue;

    logic         rclk;
    logic         arst_l;
    logic         enq_vld;
    logic [123:0] enq_data;
    logic [4:0]   enq_dest;
    logic         enq_atom;
    logic         enq_rdy;
    logic [4:0]   req_pq;
    logic         atom_pq;
    logic [123:0] data_pa;
    logic [4:0]   grant;
    logic         fifo_empty;
    logic         proto_err;

    int checks = 0;
    int errors = 0;

`ifdef SPC_PCX_REQ_CHK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    spc_pcx_req_issue dut (
        .rclk                 (rclk),
        .arst_l               (arst_l),
        .enq_vld              (enq_vld),
        .enq_data             (enq_data),
        .enq_dest             (enq_dest),
        .enq_atom             (enq_atom),
        .enq_rdy              (enq_rdy),
        .spc_pcx_req_pq_buf   (req_pq),
        .spc_pcx_atom_pq_buf  (atom_pq),
        .spc_pcx_data_pa_buf  (data_pa),
        .pcx_spc_grant_px_buf (grant),
        .fifo_empty           (fifo_empty),
        .proto_err            (proto_err)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    task automatic drive(input logic [4:0] dest, input logic [123:0] dat, input logic atom);
        enq_vld  = 1'b1;
        enq_dest = dest;
        enq_data = dat;
        enq_atom = atom;
    endtask

    task automatic idle_enq();
        enq_vld  = 1'b0;
        enq_atom = 1'b0;
    endtask

    initial begin
        rclk     = 1'b0;
        arst_l   = 1'b1;
        enq_vld  = 1'b0;
        enq_data = '0;
        enq_dest = '0;
        enq_atom = 1'b0;
        grant    = '0;

        // Reset values
        #2 arst_l = 1'b0;
        #1;
        chk("rst_req",   128'(req_pq),     128'h0);
        chk("rst_atom",  128'(atom_pq),    128'h0);
        chk("rst_data",  128'(data_pa),    128'h0);
        chk("rst_rdy",   128'(enq_rdy),    128'h1);
        chk("rst_empty", 128'(fifo_empty), 128'h1);
        chk("rst_perr",  128'(proto_err),  128'h0);
        step();
        step();
        arst_l = 1'b1;
        step();

        // Single packet: the request follows the enqueue edge by one cycle and the data by two
        drive(5'b00001, 124'hA5, 1'b0);
        step();
        idle_enq();
        chk("t1_req_before", 128'(req_pq),     128'h0);
        chk("t1_not_empty",  128'(fifo_empty), 128'h0);
        step();
        chk("t1_req",   128'(req_pq),     128'h01);
        chk("t1_atom",  128'(atom_pq),    128'h0);
        chk("t1_empty", 128'(fifo_empty), 128'h1);
        step();
        chk("t1_data",     128'(data_pa), 128'hA5);
        chk("t1_req_drop", 128'(req_pq),  128'h0);
        grant = 5'b00001;
        step();
        grant = '0;

        // Three packets to bank 2 with no grants: only two issue
        drive(5'b00100, 124'h1, 1'b0);
        step();
        drive(5'b00100, 124'h2, 1'b0);
        step();
        chk("t2_req1", 128'(req_pq), 128'h04);
        drive(5'b00100, 124'h3, 1'b0);
        step();
        idle_enq();
        chk("t2_req2",  128'(req_pq),  128'h04);
        chk("t2_data1", 128'(data_pa), 128'h1);
        step();
        chk("t2_held",      128'(req_pq),     128'h0);
        chk("t2_data2",     128'(data_pa),    128'h2);
        chk("t2_not_empty", 128'(fifo_empty), 128'h0);
        step();
        chk("t2_still_held", 128'(req_pq), 128'h0);
        grant = 5'b00100;
        step();
        grant = '0;
        chk("t2_req3_after_grant", 128'(req_pq), 128'h04);
        step();
        chk("t2_data3", 128'(data_pa), 128'h3);
        chk("t2_idle",  128'(req_pq),  128'h0);

        // Atomic to bank 1 while one packet is already outstanding there
        drive(5'b00010, 124'h10, 1'b0);
        step();
        idle_enq();
        step();
        chk("t3_pre_req", 128'(req_pq), 128'h02);
        step();
        drive(5'b00010, 124'hA1, 1'b1);
        step();
        drive(5'b00010, 124'hA2, 1'b0);
        step();
        idle_enq();
        step();
        chk("t3_held_a",      128'(req_pq),  128'h0);
        chk("t3_held_a_atom", 128'(atom_pq), 128'h0);
        step();
        chk("t3_held_b", 128'(req_pq), 128'h0);
        grant = 5'b00010;
        step();
        grant = '0;
        chk("t3_half1_req",  128'(req_pq),  128'h02);
        chk("t3_half1_atom", 128'(atom_pq), 128'h1);
        step();
        chk("t3_half2_req",  128'(req_pq),  128'h02);
        chk("t3_half2_atom", 128'(atom_pq), 128'h0);
        chk("t3_data_a1",    128'(data_pa), 128'hA1);
        step();
        chk("t3_data_a2", 128'(data_pa), 128'hA2);
        chk("t3_idle",    128'(req_pq),  128'h0);

        // Fill the FIFO behind bank 2, which already has two packets outstanding
        drive(5'b00100, 124'h41, 1'b0);
        step();
        drive(5'b00100, 124'h42, 1'b0);
        step();
        drive(5'b00100, 124'h43, 1'b0);
        step();
        drive(5'b00100, 124'h44, 1'b0);
        step();
        idle_enq();
        chk("t4_full_rdy",  128'(enq_rdy), 128'h0);
        chk("t4_full_held", 128'(req_pq),  128'h0);
        grant = 5'b00100;
        #1;
        chk("t4_rdy_same_cycle", 128'(enq_rdy), 128'h0);
        step();
        chk("t4_rdy_after_pop", 128'(enq_rdy), 128'h1);
        chk("t4_req41",         128'(req_pq),  128'h04);
        step();
        chk("t4_data41", 128'(data_pa), 128'h41);
        chk("t4_req42",  128'(req_pq),  128'h04);
        step();
        chk("t4_data42", 128'(data_pa), 128'h42);
        step();
        grant = '0;
        chk("t4_data43", 128'(data_pa), 128'h43);
        chk("t4_req44",  128'(req_pq),  128'h04);
        step();
        chk("t4_data44", 128'(data_pa),    128'h44);
        chk("t4_empty",  128'(fifo_empty), 128'h1);

        // Drain banks 1 and 2, then reset between the two halves of an atomic
        grant = 5'b00110;
        step();
        step();
        grant = '0;
        drive(5'b00010, 124'hB1, 1'b1);
        step();
        drive(5'b00010, 124'hB2, 1'b0);
        step();
        idle_enq();
        step();
        chk("t5_half1_req",  128'(req_pq),  128'h02);
        chk("t5_half1_atom", 128'(atom_pq), 128'h1);
        arst_l = 1'b0;
        #1;
        chk("t5_rst_req",   128'(req_pq),     128'h0);
        chk("t5_rst_atom",  128'(atom_pq),    128'h0);
        chk("t5_rst_data",  128'(data_pa),    128'h0);
        chk("t5_rst_empty", 128'(fifo_empty), 128'h1);
        chk("t5_rst_rdy",   128'(enq_rdy),    128'h1);
        step();
        arst_l = 1'b1;
        step();
        chk("t5_no_half2", 128'(req_pq),  128'h0);
        chk("t5_no_data",  128'(data_pa), 128'h0);
        // A stale grant must not wrap the zeroed counter. An atomic still needs a zero counter to go out.
        grant = 5'b00010;
        step();
        grant = '0;
        drive(5'b00010, 124'hC1, 1'b1);
        step();
        drive(5'b00010, 124'hC2, 1'b0);
        step();
        idle_enq();
        step();
        chk("t5_c1_req",  128'(req_pq),  128'h02);
        chk("t5_c1_atom", 128'(atom_pq), 128'h1);
        step();
        chk("t5_c2_req",  128'(req_pq),  128'h02);
        chk("t5_c2_atom", 128'(atom_pq), 128'h0);
        chk("t5_c1_data", 128'(data_pa), 128'hC1);
        step();
        chk("t5_c2_data", 128'(data_pa), 128'hC2);

        // Grant to the IO port with nothing outstanding
        grant = 5'b10000;
        step();
        grant = '0;
        chk("t6_perr", 128'(proto_err), 128'(EXP_PERR));
        step();
        step();
        chk("t6_perr_sticky", 128'(proto_err), 128'(EXP_PERR));
        arst_l = 1'b0;
        #1;
        chk("t6_perr_rst", 128'(proto_err), 128'h0);
        step();
        arst_l = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
